stream_pop_n: RTL and testbench
===============================

// Module: stream_pop_n
// PURPOSE
//   Parametrised successor to the fixed-arity stream-pop primitives (pop 1/2 heads off an
//   int stream). Pops COUNT head elements of each stream frame into parallel registered
//   outputs, then forwards the remainder of the frame with valid/ready backpressure.
//   Adds frame delimiting (last), short-frame detection and sync reset. Sits between a
//   stream producer and consumer in generated dataflow.
// PARAMETERS
//   WIDTH   8   data bits per stream element
//   COUNT   2   elements popped per frame (>=1)
//   CW      $clog2(COUNT+1)   width of capture index/count (derived, do not override)
// PORTS
//   clk          in   1            rising-edge clock
//   rst          in   1            synchronous active-high reset
//   sIn_data     in   WIDTH        input stream element
//   sIn_valid    in   1            input element present
//   sIn_last     in   1            element is final of its frame
//   sIn_ready    out  1            block accepts element this cycle
//   sOut_data    out  WIDTH        remainder stream element
//   sOut_valid   out  1            remainder element present
//   sOut_last    out  1            remainder element is final of frame
//   sOut_ready   in   1            downstream accepts element
//   dOut         out  COUNT*WIDTH  popped elements; slot k = dOut[k*WIDTH +: WIDTH], k=0 is head
//   dOut_valid   out  1            all COUNT slots hold the current frame's heads
//   dOut_count   out  CW           slots filled in current frame
//   short_err    out  1            one-cycle pulse: frame ended before COUNT pops
// BEHAVIOUR
//   - Transfer on a port = valid & ready in the same cycle.
//   - Reset (sync, highest priority): state=CAPTURE, idx=0, dOut=0, dOut_valid=0,
//     dOut_count=0, short_err=0. Mid-frame reset discards the partial frame. Input seen in
//     the reset cycle is ignored.
//   - CAPTURE:
//     - sIn_ready=1, sOut_valid=0, sOut_last=0; sOut_data don't-care (drive 0).
//     - On transfer: slot[idx] <= sIn_data; idx/dOut_count <= idx+1.
//     - First transfer of a frame (idx==0) clears dOut_valid.
//     - Transfer at idx==COUNT-1: dOut_valid <= 1 next cycle; idx <= 0;
//       state <= PASS, unless sIn_last=1 (exact-length frame), then stay in CAPTURE.
//     - Transfer with sIn_last=1 and idx<COUNT-1: short_err <= 1 for exactly one cycle;
//       dOut_valid stays 0; dOut_count keeps the filled count (idx+1); idx <= 0;
//       unfilled slots hold their old values; stay in CAPTURE.
//   - PASS (zero-latency combinational forward):
//     - sOut_data=sIn_data, sOut_valid=sIn_valid, sOut_last=sIn_last, sIn_ready=sOut_ready.
//     - Transfer with sIn_last=1 -> state <= CAPTURE. dOut held stable throughout PASS.
//   - dOut and dOut_valid are registered: valid the cycle after the COUNT-th pop and held
//     until the next frame's first pop (or reset).
//   - No combinational path from sOut_ready to sIn_ready in CAPTURE.
//   - COUNT=1: every CAPTURE transfer completes the pop; a 1-element frame never enters PASS.
//   - sIn_valid=0 or sOut_ready=0 stalls: no state change, all registers hold.
// TESTING
//   1 WIDTH=8,COUNT=2: frame 1,2,3,4(last), sOut_ready=1 -> dOut slot0=1, slot1=2,
//     dOut_valid=1 from cycle after '2'; sOut carries 3,4 with last on 4; back to CAPTURE.
//   2 Backpressure: in PASS hold sOut_ready=0 for 3 cycles -> sIn_ready=0, no loss or
//     duplication of element 3; element 3 transfers on the first ready cycle.
//   3 Short frame COUNT=3: 7,8(last) -> short_err high exactly 1 cycle, dOut_count=2,
//     dOut_valid=0, next frame 9,10,11 gives dOut={11,10,9}, dOut_valid=1.
//   4 Exact frame COUNT=2: 5,6(last) -> dOut_valid=1, no sOut_valid pulse, next element
//     starts a new frame and clears dOut_valid on its pop.
//   5 Reset mid-PASS and mid-CAPTURE (rst 1 cycle) -> all outputs 0 next cycle; the next
//     element is treated as a frame head.
//   6 COUNT=1, back-to-back 1-element frames 0x10..0x13 each with last -> dOut updates every
//     cycle, sOut_valid never asserts.

Source files
------------

// File: rtl/stream_pop_n.sv
// stream_pop_n: captures the first COUNT elements of every stream frame into
// parallel registered slots, then forwards the rest of the frame unchanged
// with valid/ready backpressure. Flags frames that end before COUNT pops.
module stream_pop_n #(
  parameter int WIDTH = 8,
  parameter int COUNT = 2,
  localparam int CW = $clog2(COUNT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         sIn_data,
  input  logic                     sIn_valid,
  input  logic                     sIn_last,
  output logic                     sIn_ready,
  output logic [WIDTH-1:0]         sOut_data,
  output logic                     sOut_valid,
  output logic                     sOut_last,
  input  logic                     sOut_ready,
  output logic [COUNT*WIDTH-1:0]   dOut,
  output logic                     dOut_valid,
  output logic [CW-1:0]            dOut_count,
  output logic                     short_err
);

  typedef enum logic {
    CAPTURE = 1'b0,
    PASS    = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] idx;
  logic          lastSlot;

  assign lastSlot = (idx == CW'(COUNT - 1));

  // Stream handshake: CAPTURE always accepts and emits nothing; PASS is a wire.
  // NOTE: always_comb gives every output a default first so no latch can form.
  always_comb begin
    sIn_ready  = 1'b1;
    sOut_data  = '0;
    sOut_valid = 1'b0;
    sOut_last  = 1'b0;
    if (state == PASS) begin
      sOut_data  = sIn_data;
      sOut_valid = sIn_valid;
      sOut_last  = sIn_last;
      sIn_ready  = sOut_ready;
    end
  end

  // Frame tracking, head capture and status flags.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // read below sees the value from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CAPTURE;
      idx        <= '0;
      dOut       <= '0;
      dOut_valid <= 1'b0;
      dOut_count <= '0;
      short_err  <= 1'b0;
    end else begin
      short_err <= 1'b0;
      case (state)
        CAPTURE: begin
          if (sIn_valid) begin
            for (int k = 0; k < COUNT; k++) begin
              if (CW'(k) == idx) dOut[k*WIDTH +: WIDTH] <= sIn_data;
            end
            dOut_count <= idx + CW'(1);
            // NOTE: when COUNT==1 the frame head is also the final pop; the
            // later assignment to dOut_valid below wins, leaving it set.
            if (idx == '0) dOut_valid <= 1'b0;
            if (lastSlot) begin
              dOut_valid <= 1'b1;
              idx        <= '0;
              if (!sIn_last) state <= PASS;
            end else if (sIn_last) begin
              short_err <= 1'b1;
              idx       <= '0;
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        PASS: begin
          if (sIn_valid && sOut_ready && sIn_last) state <= CAPTURE;
        end
        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pop_n.sv
// Bench for stream_pop_n: three instances (COUNT=2, 3, 1) share one clock and
// reset. Stimulus pushes the expected response of every input element into a
// per-instance queue; per-instance monitors pop and compare on each transfer.
module tb_stream_pop_n;

  typedef struct {
    bit          isPass;
    logic [7:0]  oData;
    logic        oLast;
    logic [23:0] dOutE;
    logic        dv;
    logic [1:0]  dc;
    logic        se;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  sInData   [3];
  logic        sInValid  [3];
  logic        sInLast   [3];
  logic        sInReady  [3];
  logic [7:0]  sOutData  [3];
  logic        sOutValid [3];
  logic        sOutLast  [3];
  logic        sOutReady [3];
  logic        dValid    [3];
  logic        shortErr  [3];
  logic [23:0] dOutW     [3];
  logic [1:0]  cntW      [3];

  logic [15:0] dOutA;
  logic [23:0] dOutB;
  logic [7:0]  dOutC;
  logic [1:0]  cntA;
  logic [1:0]  cntB;
  logic [0:0]  cntC;

  assign dOutW[0] = {8'h00, dOutA};
  assign dOutW[1] = dOutB;
  assign dOutW[2] = {16'h0000, dOutC};
  assign cntW[0]  = cntA;
  assign cntW[1]  = cntB;
  assign cntW[2]  = {1'b0, cntC};

  rec_t expQ [3][$];
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk = ~clk;

  stream_pop_n #(.WIDTH(8), .COUNT(2)) uA (
    .clk(clk), .rst(rst),
    .sIn_data(sInData[0]), .sIn_valid(sInValid[0]), .sIn_last(sInLast[0]),
    .sIn_ready(sInReady[0]),
    .sOut_data(sOutData[0]), .sOut_valid(sOutValid[0]), .sOut_last(sOutLast[0]),
    .sOut_ready(sOutReady[0]),
    .dOut(dOutA), .dOut_valid(dValid[0]), .dOut_count(cntA), .short_err(shortErr[0])
  );

  stream_pop_n #(.WIDTH(8), .COUNT(3)) uB (
    .clk(clk), .rst(rst),
    .sIn_data(sInData[1]), .sIn_valid(sInValid[1]), .sIn_last(sInLast[1]),
    .sIn_ready(sInReady[1]),
    .sOut_data(sOutData[1]), .sOut_valid(sOutValid[1]), .sOut_last(sOutLast[1]),
    .sOut_ready(sOutReady[1]),
    .dOut(dOutB), .dOut_valid(dValid[1]), .dOut_count(cntB), .short_err(shortErr[1])
  );

  stream_pop_n #(.WIDTH(8), .COUNT(1)) uC (
    .clk(clk), .rst(rst),
    .sIn_data(sInData[2]), .sIn_valid(sInValid[2]), .sIn_last(sInLast[2]),
    .sIn_ready(sInReady[2]),
    .sOut_data(sOutData[2]), .sOut_valid(sOutValid[2]), .sOut_last(sOutLast[2]),
    .sOut_ready(sOutReady[2]),
    .dOut(dOutC), .dOut_valid(dValid[2]), .dOut_count(cntC), .short_err(shortErr[2])
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic pushExp(int i, bit isPass, logic [7:0] d, bit l,
                         logic [23:0] dOutE, bit dv, logic [1:0] dc, bit se);
    rec_t r;
    r.isPass = isPass;
    r.oData  = d;
    r.oLast  = l;
    r.dOutE  = dOutE;
    r.dv     = dv;
    r.dc     = dc;
    r.se     = se;
    expQ[i].push_back(r);
  endtask

  // Present one element and hold it until accepted (bounded wait).
  task automatic send(int i, logic [7:0] d, bit l);
    bit ok;
    ok          = 1'b0;
    sInData[i]  = d;
    sInLast[i]  = l;
    sInValid[i] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sInReady[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nChecks++;
      nFails++;
      $display("FAIL send_timeout: inst %0d element %h never accepted", i, d);
    end
    @(posedge clk);
    #1;
    sInValid[i] = 1'b0;
    sInLast[i]  = 1'b0;
  endtask

  task automatic xfer(int i, logic [7:0] d, bit l, bit isPass,
                      logic [23:0] dOutE, bit dv, logic [1:0] dc, bit se);
    pushExp(i, isPass, d, l, dOutE, dv, dc, se);
    send(i, d, l);
  endtask

  // One-cycle reset with a stray element on instance 0 that must be ignored.
  task automatic pulseReset();
    rst         = 1'b1;
    sInValid[0] = 1'b1;
    sInData[0]  = 8'h99;
    sInLast[0]  = 1'b0;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    sInValid[0] = 1'b0;
    @(negedge clk);
    check("rst_dOut",       dOutW[0],     0);
    check("rst_dOut_valid", dValid[0],    0);
    check("rst_dOut_count", cntW[0],      0);
    check("rst_short_err",  shortErr[0],  0);
    check("rst_sOut_valid", sOutValid[0], 0);
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : gMon
    initial begin
      rec_t r;
      rec_t held;
      bit   pend;
      pend = 1'b0;
      forever begin
        @(negedge clk);
        if (pend) begin
          check($sformatf("post_dOut[%0d]", g),       dOutW[g],    held.dOutE);
          check($sformatf("post_dOut_valid[%0d]", g), dValid[g],   held.dv);
          check($sformatf("post_dOut_count[%0d]", g), cntW[g],     held.dc);
          check($sformatf("post_short_err[%0d]", g),  shortErr[g], held.se);
          pend = 1'b0;
        end else if (!rst) begin
          check($sformatf("idle_short_err[%0d]", g), shortErr[g], 0);
        end
        if (!rst && sInValid[g] && sInReady[g]) begin
          if (expQ[g].size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL unexpected_xfer[%0d]: data %h with no expected entry", g, sInData[g]);
          end else begin
            r = expQ[g].pop_front();
            check($sformatf("sOut_valid[%0d]", g), sOutValid[g], r.isPass);
            if (r.isPass) begin
              check($sformatf("sOut_data[%0d]", g), sOutData[g], r.oData);
              check($sformatf("sOut_last[%0d]", g), sOutLast[g], r.oLast);
            end
            held = r;
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      sInData[i]   = '0;
      sInValid[i]  = 1'b0;
      sInLast[i]   = 1'b0;
      sOutReady[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("init_dOut",       dOutW[0],  0);
    check("init_dOut_valid", dValid[0], 0);
    check("init_dOut_count", cntW[0],   0);
    check("init_sIn_ready",  sInReady[0], 1);
    @(posedge clk);
    #1;

    // 1: COUNT=2 frame 1,2,3,4(last)
    xfer(0, 8'h01, 0, 0, 24'h000001, 0, 2'd1, 0);
    xfer(0, 8'h02, 0, 0, 24'h000201, 1, 2'd2, 0);
    xfer(0, 8'h03, 0, 1, 24'h000201, 1, 2'd2, 0);
    xfer(0, 8'h04, 1, 1, 24'h000201, 1, 2'd2, 0);

    // 2: backpressure on the first PASS element
    xfer(0, 8'h11, 0, 0, 24'h000211, 0, 2'd1, 0);
    xfer(0, 8'h12, 0, 0, 24'h001211, 1, 2'd2, 0);
    sOutReady[0] = 1'b0;
    pushExp(0, 1, 8'h13, 0, 24'h001211, 1, 2'd2, 0);
    fork
      send(0, 8'h13, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_sIn_ready",   sInReady[0],  0);
          check("bp_sOut_valid",  sOutValid[0], 1);
          check("bp_sOut_data",   sOutData[0],  8'h13);
          check("bp_dOut_stable", dOutW[0],     24'h001211);
        end
        @(posedge clk);
        #1;
        sOutReady[0] = 1'b1;
      end
    join
    xfer(0, 8'h14, 1, 1, 24'h001211, 1, 2'd2, 0);

    // 4: exact-length frames never emit on sOut
    xfer(0, 8'h05, 0, 0, 24'h001205, 0, 2'd1, 0);
    xfer(0, 8'h06, 1, 0, 24'h000605, 1, 2'd2, 0);
    xfer(0, 8'h07, 0, 0, 24'h000607, 0, 2'd1, 0);
    xfer(0, 8'h08, 1, 0, 24'h000807, 1, 2'd2, 0);

    // 5: reset mid-PASS, then mid-CAPTURE
    xfer(0, 8'h21, 0, 0, 24'h000821, 0, 2'd1, 0);
    xfer(0, 8'h22, 0, 0, 24'h002221, 1, 2'd2, 0);
    xfer(0, 8'h23, 0, 1, 24'h002221, 1, 2'd2, 0);
    pulseReset();
    xfer(0, 8'h31, 0, 0, 24'h000031, 0, 2'd1, 0);
    xfer(0, 8'h32, 1, 0, 24'h003231, 1, 2'd2, 0);
    xfer(0, 8'h40, 0, 0, 24'h003240, 0, 2'd1, 0);
    pulseReset();
    xfer(0, 8'h41, 0, 0, 24'h000041, 0, 2'd1, 0);
    xfer(0, 8'h42, 1, 0, 24'h004241, 1, 2'd2, 0);

    // 3: COUNT=3 short frame 7,8(last), then 9,10,11,12(last)
    xfer(1, 8'h07, 0, 0, 24'h000007, 0, 2'd1, 0);
    xfer(1, 8'h08, 1, 0, 24'h000807, 0, 2'd2, 1);
    xfer(1, 8'h09, 0, 0, 24'h000809, 0, 2'd1, 0);
    xfer(1, 8'h0a, 0, 0, 24'h000a09, 0, 2'd2, 0);
    xfer(1, 8'h0b, 0, 0, 24'h0b0a09, 1, 2'd3, 0);
    xfer(1, 8'h0c, 1, 1, 24'h0b0a09, 1, 2'd3, 0);

    // 6: COUNT=1 back-to-back single-element frames
    xfer(2, 8'h10, 1, 0, 24'h000010, 1, 2'd1, 0);
    xfer(2, 8'h11, 1, 0, 24'h000011, 1, 2'd1, 0);
    xfer(2, 8'h12, 1, 0, 24'h000012, 1, 2'd1, 0);
    xfer(2, 8'h13, 1, 0, 24'h000013, 1, 2'd1, 0);

    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("queue_drained[%0d]", i), expQ[i].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
